key_scheduler: RTL
==================

Name: key_scheduler

Overview:
- RC4 key-scheduling (KSA) stage that sits directly upstream of the decryptor.
- First fills S-RAM with the identity permutation (S[i]=i), then runs the 256-iteration KSA swap loop using a secret key.
- On completion it pulses `finished`, which the top level routes to the decryptor's `start`.
- Shares the S-RAM port with the decryptor through a top-level mux; this block owns the port only while `busy`=1.

Parameters:
- RAM_WIDTH, 8, S-RAM data width in bits.
- RAM_LENGTH, 8, S-RAM address width in bits (256 entries).
- KEY_LENGTH, 3, secret key length in bytes.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; the block acts on its rising edge
- secretKey  in  8*KEY_LENGTH  key; byte 0 is the most significant byte
- sOut  in  RAM_WIDTH  S-RAM read data, one-cycle read latency
- sAddr  out  RAM_LENGTH  S-RAM address
- sIn  out  RAM_WIDTH  S-RAM write data
- sWren  out  1  S-RAM write enable
- busy  out  1  high from leaving IDLE through DONE, inclusive
- finished  out  1  one-cycle completion pulse
- iTap  out  8  current i (debug)
- jTap  out  8  current j (debug)

Behaviour:

Clock and reset:
- Single clock domain; every register updates on posedge clk.
- reset (synchronous, active-high) forces: state=IDLE, i=0, j=0, si=0, sj=0, key register=0.
- Reset values of outputs: sWren=0, finished=0, busy=0, sAddr=0, sIn=0.
- Reset has priority over start in the same cycle.

Start detection:
- Internal edge detector: start_sig is true when start=1 now and start=0 at the previous clock edge.
- Holding start high produces only one run.
- start_sig while `busy` is ignored.

States:
- IDLE
  - All outputs 0.
  - On start_sig: latch secretKey, clear i and j, go to INIT.
  - secretKey changes after the latch are ignored.
- INIT
  - Drive sAddr=i, sIn=i, sWren=1; then i<=i+1.
  - At i==255, the write happens, then i<=0 and go to K_ADDR_I.
  - Duration: 256 cycles.
- K_ADDR_I
  - Drive sAddr=i; sWren=0.
- K_READ_SI
  - Capture si<=sOut.
  - Compute j<=j+sOut+keybyte[i mod KEY_LENGTH], modulo 256 (8-bit wrap, carries discarded).
  - Drive sAddr=new j in the same cycle.
- K_READ_SJ
  - Capture sj<=sOut.
- K_WRITE_I
  - Drive sAddr=i, sIn=sj, sWren=1.
- K_WRITE_J
  - Drive sAddr=j, sIn=si, sWren=1.
  - If i==255, go to DONE; otherwise i<=i+1 and go to K_ADDR_I.
- DONE
  - finished=1 for exactly one cycle; clear i and j; go to IDLE.

Key indexing:
- Key byte index = i mod KEY_LENGTH.
- Byte 0 = secretKey[8*KEY_LENGTH-1 -: 8].

Latency:
- INIT occupies 256 cycles, the KSA loop 5 cycles per iteration, DONE 1 cycle.
- finished is high in the cycle beginning 1536 clock edges after the edge that left IDLE.
- busy is high for 1537 cycles.

Boundaries:
- i==j swap: both writes go to the same address, and the second write (si) leaves the entry unchanged. This is correct; no special case is allowed.
- j wraps modulo 256.
- i terminates at 255; no iteration 256.
- Reset mid-run returns to IDLE at the next edge with sWren=0; S-RAM contents are then undefined and no finished pulse is emitted.
- A new start_sig after DONE reruns the full sequence, including INIT.

Test Plan:
- Reset with start=0 -> sWren, finished and busy stay 0 for 20 cycles; iTap=jTap=0.
- secretKey=24'h000000, start pulse -> after the INIT phase, the RAM model holds S[k]=k for all k; during INIT, sWren=1 for exactly 256 consecutive cycles.
- secretKey=24'h000000, full run:
  - Iterations i=0 and i=1 are self-swaps (j=0, then j=1).
  - Iteration i=2 gives j=3, so S[2]=3 and S[3]=2.
  - The final S-RAM matches a software KSA model byte-for-byte.
- secretKey=24'h00033C -> the final S-RAM matches the software model; finished pulses once, 1536 edges after leaving IDLE; busy deasserts the cycle after finished.
- start held high for 3000 cycles -> exactly one run and one finished pulse; a second rising edge then produces a second full run.
- Assert reset at cycle 700 of a run -> IDLE next cycle, sWren=0, no finished pulse; a following start completes normally with the correct final S-RAM.

Source files
------------

// File: rtl/key_scheduler.sv
// RC4 key-scheduling stage: fills S-RAM with the identity permutation, then
// runs the 256-iteration KSA swap loop with the latched secret key and pulses
// `finished` when the permutation is complete. Owns the S-RAM port while busy.
module key_scheduler #(
    parameter int RAM_WIDTH  = 8,
    parameter int RAM_LENGTH = 8,
    parameter int KEY_LENGTH = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [8*KEY_LENGTH-1:0] secretKey,
    input  logic [RAM_WIDTH-1:0]    sOut,
    output logic [RAM_LENGTH-1:0]   sAddr,
    output logic [RAM_WIDTH-1:0]    sIn,
    output logic                    sWren,
    output logic                    busy,
    output logic                    finished,
    output logic [7:0]              iTap,
    output logic [7:0]              jTap
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        K_ADDR_I,
        K_READ_SI,
        K_READ_SJ,
        K_WRITE_I,
        K_WRITE_J,
        DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [7:0]                i_q, i_d;
    logic [7:0]                j_q, j_d;
    logic [RAM_WIDTH-1:0]      si_q, si_d;
    logic [RAM_WIDTH-1:0]      sj_q, sj_d;
    logic [8*KEY_LENGTH-1:0]   key_q, key_d;
    logic                      start_prev_q;
    logic                      start_sig;
    logic [7:0]                key_byte;
    int                        key_idx;

    assign start_sig = start & ~start_prev_q;

    // Select key byte i mod KEY_LENGTH; byte 0 sits in the most significant slot.
    always_comb begin
        key_idx  = int'(i_q) % KEY_LENGTH;
        key_byte = key_q[8*KEY_LENGTH-1-8*key_idx -: 8];
    end

    // Next-state and datapath updates for the fill and swap sequence.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        si_d    = si_q;
        sj_d    = sj_q;
        key_d   = key_q;
        case (state_q)
            IDLE: begin
                if (start_sig) begin
                    key_d   = secretKey;
                    i_d     = 8'd0;
                    j_d     = 8'd0;
                    state_d = INIT;
                end
            end
            INIT: begin
                i_d = i_q + 8'd1;
                if (i_q == 8'hFF) state_d = K_ADDR_I;
            end
            K_ADDR_I: state_d = K_READ_SI;
            K_READ_SI: begin
                // sOut now holds S[i]; j update is 8-bit and wraps naturally.
                si_d    = sOut;
                j_d     = j_q + 8'(sOut) + key_byte;
                state_d = K_READ_SJ;
            end
            K_READ_SJ: begin
                sj_d    = sOut;
                state_d = K_WRITE_I;
            end
            K_WRITE_I: state_d = K_WRITE_J;
            K_WRITE_J: begin
                if (i_q == 8'hFF) begin
                    state_d = DONE;
                end else begin
                    i_d     = i_q + 8'd1;
                    state_d = K_ADDR_I;
                end
            end
            DONE: begin
                i_d     = 8'd0;
                j_d     = 8'd0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // S-RAM port drive decoded from the current state; the j read address is
    // forwarded from the update so the S[j] read lands one cycle later.
    always_comb begin
        sAddr    = '0;
        sIn      = '0;
        sWren    = 1'b0;
        finished = 1'b0;
        case (state_q)
            INIT: begin
                sAddr = RAM_LENGTH'(i_q);
                sIn   = RAM_WIDTH'(i_q);
                sWren = 1'b1;
            end
            K_ADDR_I:  sAddr = RAM_LENGTH'(i_q);
            K_READ_SI: sAddr = RAM_LENGTH'(j_d);
            K_READ_SJ: sAddr = RAM_LENGTH'(j_q);
            K_WRITE_I: begin
                sAddr = RAM_LENGTH'(i_q);
                sIn   = sj_q;
                sWren = 1'b1;
            end
            K_WRITE_J: begin
                sAddr = RAM_LENGTH'(j_q);
                sIn   = si_q;
                sWren = 1'b1;
            end
            DONE:    finished = 1'b1;
            default: ;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign iTap = i_q;
    assign jTap = j_q;

    // State registers; the start history is tracked through reset so a start
    // held across reset is not seen as a fresh edge.
    always_ff @(posedge clk) begin
        start_prev_q <= start;
        if (reset) begin
            state_q <= IDLE;
            i_q     <= 8'd0;
            j_q     <= 8'd0;
            si_q    <= '0;
            sj_q    <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            key_q   <= key_d;
        end
    end

endmodule
